// File: rtl/water_inlet_arbiter.sv
// Round-robin owner selection for one shared water-inlet valve, with hold quantum, dead-time and leak lockout.
// Optional per-requester usage counters: define WATER_ARB_USAGE_CNT_EN.
//
// state | meaning
// IDLE  | valve closed, arbitrating pending requests from the priority pointer
// GRANT | one machine owns the valve, hold counter running
// DEAD  | valve closed for DEADTIME cycles between owners
// FAULT | leak present, valve forced closed
module water_inlet_arbiter #(
  parameter int N_REQ    = 4,
  parameter int QUANTUM  = 1000,
  parameter int DEADTIME = 4,
  parameter int QW       = 16,
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_leak,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_gnt_id,
  output logic             o_valve_open,
  output logic             o_busy,
  output logic             o_fault
`ifdef WATER_ARB_USAGE_CNT_EN
  ,
  input  logic [IW-1:0]    i_cnt_sel,
  output logic [15:0]      o_cnt
`endif
);

  localparam int DW = (DEADTIME > 2) ? $clog2(DEADTIME) : 1;
  localparam logic [QW-1:0] HOLD_LAST = QW'(QUANTUM - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'((DEADTIME > 0) ? DEADTIME - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DEAD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [QW-1:0] hold;
  logic [DW-1:0] dead;

  logic          sel_any;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] ptr_nxt;
  logic          owner_req;
  logic          others_req;
  logic          hold_last;
  logic          dead_last;

  // Walk downward so the request closest to the pointer overwrites the rest.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[IW'((int'(ptr) + k) % N_REQ)]) begin
        sel_any = 1'b1;
        sel_idx = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign ptr_nxt    = (o_gnt_id == IW'(N_REQ - 1)) ? '0 : o_gnt_id + 1'b1;
  assign owner_req  = |(i_req & o_gnt);
  assign others_req = |(i_req & ~o_gnt);
  assign hold_last  = (hold == HOLD_LAST);
  assign dead_last  = (dead == DEAD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold     <= '0;
      dead     <= '0;
      o_gnt    <= '0;
      o_gnt_id <= '0;
    end else if (i_leak) begin
      state    <= FAULT;
      hold     <= '0;
      dead     <= '0;
      o_gnt    <= '0;
      o_gnt_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            state    <= GRANT;
            hold     <= '0;
            o_gnt    <= N_REQ'(1) << sel_idx;
            o_gnt_id <= sel_idx;
          end
        end
        GRANT: begin
          if (!owner_req || (hold_last && others_req)) begin
            state    <= (DEADTIME == 0) ? IDLE : DEAD;
            ptr      <= ptr_nxt;
            hold     <= '0;
            dead     <= '0;
            o_gnt    <= '0;
            o_gnt_id <= '0;
          end else if (hold_last) begin
            hold <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        DEAD: begin
          if (dead_last) begin
            state <= IDLE;
            dead  <= '0;
          end else begin
            dead <= dead + 1'b1;
          end
        end
        FAULT: begin
          state <= (DEADTIME == 0) ? IDLE : DEAD;
          dead  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_valve_open = |o_gnt;
  assign o_busy       = (state != IDLE);
  assign o_fault      = (state == FAULT);

`ifdef WATER_ARB_USAGE_CNT_EN
  logic [15:0] use_cnt [N_REQ];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_REQ; i++) use_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (o_gnt[i] && (use_cnt[i] != 16'hFFFF)) use_cnt[i] <= use_cnt[i] + 16'd1;
      end
    end
  end

  assign o_cnt = (int'(i_cnt_sel) < N_REQ) ? use_cnt[i_cnt_sel] : 16'h0000;
`endif

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Directed bench for water_inlet_arbiter with N_REQ=4, QUANTUM=8, DEADTIME=2.
module tb_water_inlet_arbiter;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic       i_leak;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_id;
  logic       o_valve_open;
  logic       o_busy;
  logic       o_fault;
`ifdef WATER_ARB_USAGE_CNT_EN
  logic [1:0]  i_cnt_sel;
  logic [15:0] o_cnt;
`endif

  int total;
  int passed;

  water_inlet_arbiter #(
    .N_REQ(4), .QUANTUM(8), .DEADTIME(2), .QW(16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_leak      (i_leak),
    .o_gnt       (o_gnt),
    .o_gnt_id    (o_gnt_id),
    .o_valve_open(o_valve_open),
    .o_busy      (o_busy),
    .o_fault     (o_fault)
`ifdef WATER_ARB_USAGE_CNT_EN
    ,
    .i_cnt_sel   (i_cnt_sel),
    .o_cnt       (o_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req   = '0;
    i_leak  = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    i_rst_n = 1'b0;
    i_req   = '0;
    i_leak  = 1'b0;
`ifdef WATER_ARB_USAGE_CNT_EN
    i_cnt_sel = '0;
`endif
    tick();
    chk("rst_gnt", {28'd0, o_gnt}, 32'h0);
    chk("rst_busy", {31'd0, o_busy}, 32'h0);
    i_rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", {28'd0, o_gnt}, 32'h0);
    chk("post_rst_busy", {31'd0, o_busy}, 32'h0);
    chk("post_rst_fault", {31'd0, o_fault}, 32'h0);
    chk("post_rst_valve", {31'd0, o_valve_open}, 32'h0);

    // single request
    i_req = 4'b0001;
    tick();
    chk("single_gnt", {28'd0, o_gnt}, 32'h1);
    chk("single_valve", {31'd0, o_valve_open}, 32'h1);
    chk("single_id", {30'd0, o_gnt_id}, 32'h0);
    i_req = 4'b0000;
    tick();
    chk("single_rel_gnt", {28'd0, o_gnt}, 32'h0);
    chk("single_dead0_busy", {31'd0, o_busy}, 32'h1);
    tick();
    chk("single_dead1_busy", {31'd0, o_busy}, 32'h1);
    tick();
    chk("single_idle_busy", {31'd0, o_busy}, 32'h0);

    // contention 0101 from fresh pointer
    do_reset();
    i_req = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("cont_a_gnt", {28'd0, o_gnt}, 32'h1);
    end
    chk("cont_a_id", {30'd0, o_gnt_id}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cont_gap1", {28'd0, o_gnt}, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("cont_b_gnt", {28'd0, o_gnt}, 32'h4);
    end
    chk("cont_b_id", {30'd0, o_gnt_id}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cont_gap2", {28'd0, o_gnt}, 32'h0);
      chk("cont_gap2_id", {30'd0, o_gnt_id}, 32'h0);
    end
    tick();
    chk("cont_c_gnt", {28'd0, o_gnt}, 32'h1);
    chk("cont_c_id", {30'd0, o_gnt_id}, 32'h0);

    // uncontested hold past several quanta
    do_reset();
    i_req = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("uncont_gnt", {28'd0, o_gnt}, 32'h2);
    end

    // leak during grant of machine 3; pointer first moved to 2
    do_reset();
    i_req = 4'b0010;
    tick();
    i_req = 4'b0000;
    tick();
    tick();
    tick();
    chk("leak_pre_idle", {31'd0, o_busy}, 32'h0);
    i_req = 4'b1000;
    tick();
    chk("leak_own_gnt", {28'd0, o_gnt}, 32'h8);
    chk("leak_own_id", {30'd0, o_gnt_id}, 32'h3);
    tick();
    i_leak = 1'b1;
    i_req  = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("leak_fault", {31'd0, o_fault}, 32'h1);
      chk("leak_gnt", {28'd0, o_gnt}, 32'h0);
    end
    i_leak = 1'b0;
    tick();
    chk("leak_dead0_fault", {31'd0, o_fault}, 32'h0);
    chk("leak_dead0_busy", {31'd0, o_busy}, 32'h1);
    chk("leak_dead0_gnt", {28'd0, o_gnt}, 32'h0);
    tick();
    chk("leak_dead1_busy", {31'd0, o_busy}, 32'h1);
    tick();
    chk("leak_idle_busy", {31'd0, o_busy}, 32'h0);
    chk("leak_idle_gnt", {28'd0, o_gnt}, 32'h0);
    tick();
    chk("leak_regrant_gnt", {28'd0, o_gnt}, 32'h8);
    chk("leak_regrant_id", {30'd0, o_gnt_id}, 32'h3);

    // async reset between edges
    do_reset();
    i_req = 4'b0100;
    tick();
    chk("arst_pre_gnt", {28'd0, o_gnt}, 32'h4);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_gnt", {28'd0, o_gnt}, 32'h0);
    chk("arst_valve", {31'd0, o_valve_open}, 32'h0);
    chk("arst_busy", {31'd0, o_busy}, 32'h0);
    #1;
    i_rst_n = 1'b1;
    i_req   = 4'b1111;
    tick();
    chk("arst_regrant", {28'd0, o_gnt}, 32'h1);

`ifdef WATER_ARB_USAGE_CNT_EN
    do_reset();
    i_req = 4'b0010;
    for (int i = 0; i < 8; i++) tick();
    i_req = 4'b0000;
    tick();
    i_cnt_sel = 2'd1;
    #1;
    chk("cnt_sel1", {16'd0, o_cnt}, 32'd8);
    i_cnt_sel = 2'd0;
    #1;
    chk("cnt_sel0", {16'd0, o_cnt}, 32'd0);
    tick();
    tick();
    i_req = 4'b0010;
    for (int i = 0; i < 70000; i++) tick();
    i_cnt_sel = 2'd1;
    #1;
    chk("cnt_sat", {16'd0, o_cnt}, 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
